// File: rtl/lsu_32bit_if.sv
// lsu_32bit_if: memory-side request/response bus between the LSU and memory
interface lsu_32bit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master (output req, we, addr, wdata, wstrb, input gnt, rvalid, rdata);
  modport slave (input req, we, addr, wdata, wstrb, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_32bit.sv
// lsu_32bit: RV32I load/store unit with alignment checks, lane formatting and a request/read timeout
module lsu_32bit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_start,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_err,
  output logic [31:0] o_load_data,
  lsu_32bit_if.master mem
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;
  state_t      r_state, w_next;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr, r_store_data, r_load_data;
  logic [1:0]  r_err, w_err;
  logic [7:0]  r_cnt;
  logic        w_illegal, w_misal, w_tmo;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_fmt;
  assign w_illegal = i_is_store ? (i_funct3 >= 3'b011) : (i_funct3 == 3'b011 || i_funct3[2:1] == 2'b11);
  assign w_misal = (i_funct3[1:0] == 2'b01 && i_addr[0]) || (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00);
  assign w_tmo = r_cnt == 8'(TIMEOUT - 1);
  always_comb begin
    w_next = r_state;
    w_err  = r_err;
    unique case (r_state)
      IDLE: if (i_start) begin
        w_next = (w_illegal || w_misal) ? DONE : REQ;
        w_err  = w_illegal ? 2'b10 : w_misal ? 2'b01 : 2'b00;
      end
      REQ: if (mem.gnt) w_next = r_is_store ? DONE : WAIT_R;
        else if (w_tmo) begin
          w_next = DONE;
          w_err  = 2'b11;
        end
      WAIT_R: if (mem.rvalid) w_next = DONE;
        else if (w_tmo) begin
          w_next = DONE;
          w_err  = 2'b11;
        end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  assign w_byte = mem.rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? mem.rdata[31:16] : mem.rdata[15:0];
  assign w_fmt = r_funct3[1] ? mem.rdata :
                 r_funct3[0] ? {{16{~r_funct3[2] & w_half[15]}}, w_half} :
                               {{24{~r_funct3[2] & w_byte[7]}}, w_byte};
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_is_store   <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr       <= 32'h0;
      r_store_data <= 32'h0;
      r_load_data  <= 32'h0;
      r_err        <= 2'b00;
      r_cnt        <= 8'h0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err;
      r_cnt   <= (r_state == w_next && (r_state == REQ || r_state == WAIT_R)) ? r_cnt + 8'h1 : 8'h0;
      if (r_state == IDLE && i_start) begin
        r_is_store   <= i_is_store;
        r_funct3     <= i_funct3;
        r_addr       <= i_addr;
        r_store_data <= i_store_data;
      end
      if (r_state == WAIT_R && mem.rvalid) r_load_data <= w_fmt;
    end
  end
  assign o_busy      = r_state != IDLE;
  assign o_done      = r_state == DONE;
  assign o_err       = r_err;
  assign o_load_data = r_load_data;
  assign mem.req     = r_state == REQ;
  assign mem.we      = r_state == REQ && r_is_store;
  assign mem.addr    = {r_addr[31:2], 2'b00};
  assign mem.wdata   = r_funct3[1:0] == 2'b10 ? r_store_data :
                       r_funct3[0] ? {2{r_store_data[15:0]}} : {4{r_store_data[7:0]}};
  assign mem.wstrb   = !r_is_store ? 4'b0000 :
                       r_funct3 == 3'b010 ? 4'b1111 :
                       r_funct3 == 3'b001 ? 4'b0011 << r_addr[1:0] :
                       r_funct3 == 3'b000 ? 4'b0001 << r_addr[1:0] : 4'b0000;
endmodule

// File: tb/tb_lsu_32bit.sv
// tb_lsu_32bit: directed checks of lsu_32bit with a short timeout so abort paths are reachable
module tb_lsu_32bit;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0, is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0, store_data = 32'h0;
  logic        busy, done;
  logic [1:0]  err;
  logic [31:0] load_data;
  int n_vec = 0, n_err = 0;
  lsu_32bit_if bus();
  lsu_32bit #(.TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn), .i_start(start), .i_is_store(is_store), .i_funct3(funct3),
    .i_addr(addr), .i_store_data(store_data), .o_busy(busy), .o_done(done), .o_err(err),
    .o_load_data(load_data), .mem(bus)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
    start = 1'b1; is_store = 1'b0; funct3 = f3; addr = a; bus.gnt = 1'b1;
    tick;
    start = 1'b0;
    chk({tag, " req"}, 32'(bus.req), 32'h1);
    chk({tag, " addr"}, bus.addr, {a[31:2], 2'b00});
    chk({tag, " wstrb"}, 32'(bus.wstrb), 32'h0);
    tick;
    bus.gnt = 1'b0;
    chk({tag, " wait done"}, 32'(done), 32'h0);
    chk({tag, " wait req"}, 32'(bus.req), 32'h0);
    bus.rvalid = 1'b1; bus.rdata = rd;
    tick;
    bus.rvalid = 1'b0;
    chk({tag, " done"}, 32'(done), 32'h1);
    chk({tag, " err"}, 32'(err), 32'h0);
    chk({tag, " data"}, load_data, exp);
    tick;
    chk({tag, " idle"}, 32'(busy), 32'h0);
  endtask
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] wd, input logic [3:0] ws);
    start = 1'b1; is_store = 1'b1; funct3 = f3; addr = a; store_data = sd; bus.gnt = 1'b1;
    tick;
    start = 1'b0;
    chk({tag, " req"}, 32'(bus.req), 32'h1);
    chk({tag, " we"}, 32'(bus.we), 32'h1);
    chk({tag, " wdata"}, bus.wdata, wd);
    chk({tag, " wstrb"}, 32'(bus.wstrb), 32'(ws));
    tick;
    bus.gnt = 1'b0;
    chk({tag, " done"}, 32'(done), 32'h1);
    chk({tag, " err"}, 32'(err), 32'h0);
    tick;
    chk({tag, " idle"}, 32'(busy), 32'h0);
  endtask
  task automatic do_rej(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [1:0] exp_err);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; bus.gnt = 1'b1;
    tick;
    start = 1'b0;
    chk({tag, " done"}, 32'(done), 32'h1);
    chk({tag, " err"}, 32'(err), 32'(exp_err));
    chk({tag, " req"}, 32'(bus.req), 32'h0);
    tick;
    bus.gnt = 1'b0;
    chk({tag, " after"}, 32'({done, busy, bus.req}), 32'h0);
  endtask
  initial begin
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;
    tick; tick;
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst done", 32'(done), 32'h0);
    chk("rst err", 32'(err), 32'h0);
    chk("rst load_data", load_data, 32'h0);
    chk("rst req/we", 32'({bus.req, bus.we}), 32'h0);
    chk("rst addr", bus.addr, 32'h0);
    chk("rst wdata", bus.wdata, 32'h0);
    chk("rst wstrb", 32'(bus.wstrb), 32'h0);
    resetn = 1'b1;
    tick;
    do_load("LB", 3'b000, 32'h1003, 32'h80AABBCC, 32'hFFFFFF80);
    do_load("LBU", 3'b100, 32'h1001, 32'h80AABBCC, 32'h000000BB);
    do_load("LHU", 3'b101, 32'h1002, 32'h80AABBCC, 32'h000080AA);
    do_load("LH", 3'b001, 32'h1000, 32'h1234F00D, 32'hFFFFF00D);
    do_load("LW", 3'b010, 32'h1004, 32'hCAFE0123, 32'hCAFE0123);
    do_store("SH", 3'b001, 32'h2002, 32'h1234ABCD, 32'hABCDABCD, 4'b1100);
    do_store("SB", 3'b000, 32'h2001, 32'h000000EF, 32'hEFEFEFEF, 4'b0010);
    do_store("SW", 3'b010, 32'h3000, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111);
    chk("store keeps load_data", load_data, 32'hCAFE0123);
    do_rej("LW mis", 1'b0, 3'b010, 32'h0001, 2'b01);
    do_rej("LH mis", 1'b0, 3'b001, 32'h0003, 2'b01);
    do_rej("SW mis", 1'b1, 3'b010, 32'h0002, 2'b01);
    do_rej("L f3=011", 1'b0, 3'b011, 32'h0000, 2'b10);
    do_rej("S f3=100", 1'b1, 3'b100, 32'h0000, 2'b10);
    do_rej("L f3=110 prio", 1'b0, 3'b110, 32'h0001, 2'b10);
    chk("rej keeps load_data", load_data, 32'hCAFE0123);
    // store stalled 3 cycles without grant, granted on the last cycle before timeout
    start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h40; store_data = 32'h11223344;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall req", 32'(bus.req), 32'h1);
      chk("stall stable", {bus.addr[7:0], bus.wdata[23:0]}, 32'h40223344);
      chk("stall strb/we", 32'({bus.wstrb, bus.we}), 32'h1F);
      chk("stall done", 32'(done), 32'h0);
      start = (i == 1); addr = 32'h999; is_store = 1'b0;
      bus.gnt = (i == 3);
      tick;
    end
    start = 1'b0; bus.gnt = 1'b0;
    chk("stall done", 32'(done), 32'h1);
    chk("stall err", 32'(err), 32'h0);
    tick;
    chk("busy start ignored", 32'(busy), 32'h0);
    chk("busy start addr", bus.addr, 32'h40);
    // load never granted: request aborts after 4 cycles
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h50;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("req tmo req", 32'(bus.req), 32'h1);
      tick;
    end
    chk("req tmo done", 32'(done), 32'h1);
    chk("req tmo err", 32'(err), 32'h3);
    chk("req tmo req drop", 32'(bus.req), 32'h0);
    tick;
    // load granted, read data never arrives
    start = 1'b1; bus.gnt = 1'b1;
    tick;
    start = 1'b0;
    tick;
    bus.gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rd tmo wait", 32'({done, busy}), 32'h1);
      tick;
    end
    chk("rd tmo done", 32'(done), 32'h1);
    chk("rd tmo err", 32'(err), 32'h3);
    chk("rd tmo load_data", load_data, 32'hCAFE0123);
    tick;
    // reset during read wait, then a stale rvalid
    start = 1'b1; funct3 = 3'b010; addr = 32'h60; bus.gnt = 1'b1;
    tick;
    start = 1'b0;
    tick;
    bus.gnt = 1'b0;
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    chk("mid rst busy", 32'(busy), 32'h0);
    chk("mid rst load_data", load_data, 32'h0);
    bus.rvalid = 1'b1; bus.rdata = 32'h55;
    tick;
    bus.rvalid = 1'b0;
    chk("stale rvalid done", 32'({done, busy}), 32'h0);
    chk("stale rvalid data", load_data, 32'h0);
    tick;
    chk("stale rvalid later", 32'(done), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lsu_32bit.md
LSU_32BIT -- requirements
Module: lsu_32bit

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles spent in REQ or WAIT_R before abort (range 1..255).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request strobe; sampled only when busy=0.
REQ-005 is_store  input  1  1=store, 0=load.
REQ-006 funct3  input  3  RV32I width code: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-007 addr  input  32  byte address, the registered ALU result.
REQ-008 store_data  input  32  rs2 value.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  2  status, valid with done: 00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.
REQ-012 load_data  output  32  formatted load result.
REQ-013 mem_req  output  1  memory request.
REQ-014 mem_we  output  1  1=write.
REQ-015 mem_addr  output  32  word address: {addr[31:2],2'b00}.
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_wstrb  output  4  byte write enables; 0000 on loads.
REQ-018 mem_gnt  input  1  memory accepts request this cycle.
REQ-019 mem_rvalid  input  1  read data valid.
REQ-020 mem_rdata  input  32  read word.

Function
REQ-021 FSM states: IDLE, REQ, WAIT_R, DONE.
REQ-022 IDLE: on start=1, capture is_store, funct3, addr, store_data; go to DONE if the access is illegal or misaligned, else go to REQ.
REQ-023 Illegal: load funct3 in {011,110,111}; store funct3 >= 011. Illegal takes priority over misaligned.
REQ-024 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00. Byte accesses are never misaligned.
REQ-025 A rejected access SHALL never assert mem_req.
REQ-026 REQ: mem_req=1; mem_we, mem_addr, mem_wdata and mem_wstrb stay constant until mem_gnt=1.
REQ-027 REQ with mem_gnt=1: store goes to DONE; load goes to WAIT_R.
REQ-028 mem_rvalid is sampled only in WAIT_R, so the earliest sample is the cycle after the grant; rvalid in any other state is ignored.
REQ-029 WAIT_R with mem_rvalid=1: register the formatted load_data and go to DONE.
REQ-030 DONE: done=1 for exactly one cycle with err valid; the next state is IDLE. start is ignored while busy=1.
REQ-031 Timeout: an 8-bit counter clears on entry to REQ and on entry to WAIT_R, and increments each cycle while in either state. When it reaches TIMEOUT without the awaited gnt or rvalid, drop mem_req, go to DONE with err=11, and leave load_data unchanged.
REQ-032 Store lanes, with o=addr[1:0]:
 - SB: wdata={4{sd[7:0]}}, wstrb=0001<<o.
 - SH: wdata={2{sd[15:0]}}, wstrb=0011<<o.
 - SW: wdata=sd, wstrb=1111.
REQ-033 Load lane selection uses byte offset addr[1:0]: LB/LBU take byte o; LH/LHU take the halfword at o[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
REQ-034 load_data updates only on a successful load and holds its value otherwise, including on stores and errors.
REQ-035 Minimum latency with gnt on the first REQ cycle: store done 2 cycles after start; load with rvalid on the next cycle, done 3 cycles after start; rejected access, done 1 cycle after start.

Reset
REQ-036 With resetn=0 at a clock edge:
 - State goes to IDLE and the counter clears.
 - busy, done, mem_req, mem_we = 0; err = 00.
 - load_data, mem_addr, mem_wdata = 0; mem_wstrb = 0000.
REQ-037 Reset mid-transaction aborts without asserting done. A later mem_rvalid for the aborted load SHALL be ignored.

Verification
REQ-038 LB, addr=0x1003, mem_rdata=0x80AABBCC, gnt immediate, rvalid next cycle -> mem_addr=0x1000, load_data=0xFFFFFF80, err=00, done 3 cycles after start.
REQ-039 SH, addr=0x2002, store_data=0x1234ABCD -> mem_wdata=0xABCDABCD, mem_wstrb=1100, mem_we=1; done 2 cycles after start.
REQ-040 LW, addr=0x0001 -> done the cycle after start with err=01, mem_req never high. Load funct3=011 -> err=10.
REQ-041 SW with gnt held low 3 cycles -> mem_req stays high with stable outputs for 4 cycles, then done; a start pulse issued while busy is ignored.
REQ-042 TIMEOUT=4, load granted but rvalid never asserted -> done with err=11 after 4 cycles in WAIT_R, load_data unchanged.
REQ-043 resetn low while in WAIT_R, then rvalid -> state IDLE, no done pulse, load_data=0.
